reset_led_ctrl: RTL and testbench



---
 rtl/reset_led_ctrl.sv | 166 ++++++++++++++++
 tb/tb_reset_led_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_led_ctrl.sv
// Reset sequencer for the control clock domain.
// Two independent reset pulse channels (DC and optional), each with retrigger
// and a post-release holdoff window, plus the shared status LED / reset pin
// driver with a built-in triangle-ramp glow PWM.
module reset_led_ctrl #(
    parameter int unsigned PULSE_CYCLES   = 8_000_000,
    parameter int unsigned HOLDOFF_CYCLES = 800_000,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned SLOW_BIT       = 26,
    parameter int unsigned FAST_BIT       = 22
) (
    input  logic       clock,
    input  logic       nreset,
    input  logic       reset_dc_req,
    input  logic       reset_opt_req,
    input  logic [7:0] reset_conf,
    input  logic       pll_ready,
    input  logic       resync_active,
    input  logic       adv_ready,
    output logic       dc_nreset_oe,
    output logic       opt_nreset_oe,
    output logic       led_oe,
    output logic       led_out,
    output logic       busy
);

    localparam int unsigned GLOW_W = SLOW_BIT + 1;

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_HOLDOFF = 2'd2
    } chan_state_e;

    typedef struct packed {
        chan_state_e      state;
        logic [CNT_W-1:0] cnt;
    } chan_t;

    // One step of a reset channel. Both channels share this so they cannot
    // drift apart; a request during ASSERT restarts the pulse, a request
    // during HOLDOFF is dropped.
    function automatic chan_t chan_next(input chan_t cur, input logic req);
        chan_t nxt;
        nxt = cur;
        case (cur.state)
            ST_IDLE: begin
                if (req) begin
                    nxt.state = ST_ASSERT;
                    nxt.cnt   = '0;
                end
            end
            ST_ASSERT: begin
                if (req) begin
                    nxt.cnt = '0;
                end else if (cur.cnt == PULSE_LAST) begin
                    nxt.state = ST_HOLDOFF;
                    nxt.cnt   = '0;
                end else begin
                    nxt.cnt = cur.cnt + CNT_W'(1);
                end
            end
            ST_HOLDOFF: begin
                if (cur.cnt == HOLD_LAST) begin
                    nxt.state = ST_IDLE;
                    nxt.cnt   = '0;
                end else begin
                    nxt.cnt = cur.cnt + CNT_W'(1);
                end
            end
            default: begin
                nxt.state = ST_IDLE;
                nxt.cnt   = '0;
            end
        endcase
        return nxt;
    endfunction

    chan_t             dc_q, dc_d;
    chan_t             opt_q, opt_d;
    logic              dc_oe_q, dc_oe_d;
    logic              opt_oe_q, opt_oe_d;
    logic              busy_q, busy_d;
    logic [GLOW_W-1:0] glow_q, glow_d;
    logic              led_oe_q, led_oe_d;
    logic              led_out_q, led_out_d;

    logic [7:0]        slow_level, fast_level;
    logic              slow_on, fast_on;

    // Triangle ramp: the 8 bits below the period MSB count up, then count
    // down once the MSB sets; comparing against the low byte gives the PWM.
    assign slow_level = glow_q[SLOW_BIT-1 -: 8] ^ {8{glow_q[SLOW_BIT]}};
    assign fast_level = glow_q[FAST_BIT-1 -: 8] ^ {8{glow_q[FAST_BIT]}};
    assign slow_on    = (glow_q[7:0] < slow_level);
    assign fast_on    = (glow_q[7:0] < fast_level);

    // Channel next-state, busy and glow counter advance.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        dc_d     = chan_next(dc_q, reset_dc_req);
        opt_d    = chan_next(opt_q, reset_opt_req);
        dc_oe_d  = (dc_d.state == ST_ASSERT);
        opt_oe_d = (opt_d.state == ST_ASSERT);
        busy_d   = (dc_d.state != ST_IDLE) || (opt_d.state != ST_IDLE);
        glow_d   = glow_q + GLOW_W'(1);
    end

    // LED mux; mirror modes use the next oe so the pin moves on the same edge
    // as the channel output.
    always_comb begin
        led_oe_d  = 1'b1;
        led_out_d = 1'b1;
        if (reset_conf == 8'd2) begin
            led_oe_d  = dc_oe_d;
            led_out_d = 1'b0;
        end else if (reset_conf != 8'd0) begin
            led_oe_d  = opt_oe_d;
            led_out_d = 1'b0;
        end else if (!pll_ready) begin
            led_out_d = 1'b1;
        end else if (resync_active) begin
            led_out_d = ~fast_on;
        end else if (adv_ready) begin
            led_out_d = 1'b0;
        end else begin
            led_out_d = ~slow_on;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!nreset) begin
            dc_q      <= '{state: ST_IDLE, cnt: '0};
            opt_q     <= '{state: ST_IDLE, cnt: '0};
            dc_oe_q   <= 1'b0;
            opt_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            glow_q    <= '0;
            led_oe_q  <= 1'b1;
            led_out_q <= 1'b1;
        end else begin
            dc_q      <= dc_d;
            opt_q     <= opt_d;
            dc_oe_q   <= dc_oe_d;
            opt_oe_q  <= opt_oe_d;
            busy_q    <= busy_d;
            glow_q    <= glow_d;
            led_oe_q  <= led_oe_d;
            led_out_q <= led_out_d;
        end
    end

    assign dc_nreset_oe  = dc_oe_q;
    assign opt_nreset_oe = opt_oe_q;
    assign busy          = busy_q;
    assign led_oe        = led_oe_q;
    assign led_out       = led_out_q;

endmodule

// File: tb/tb_reset_led_ctrl.sv
// Self-checking bench for reset_led_ctrl: a cycle model pushes expected
// outputs at each rising edge, a checker pops and compares at the falling edge.
module tb_reset_led_ctrl;

    localparam int P  = 10;
    localparam int H  = 5;
    localparam int SB = 12;
    localparam int FB = 10;
    localparam int GMOD = 1 << (SB + 1);

    logic       clock = 1'b0;
    logic       nreset;
    logic       reset_dc_req;
    logic       reset_opt_req;
    logic [7:0] reset_conf;
    logic       pll_ready;
    logic       resync_active;
    logic       adv_ready;
    logic       dc_nreset_oe;
    logic       opt_nreset_oe;
    logic       led_oe;
    logic       led_out;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic dc;
        logic opt;
        logic busy;
        logic led_oe;
        logic led_out;
    } exp_t;

    exp_t sb_q[$];

    // Model state: remaining pulse cycles and remaining holdoff cycles.
    int dc_rem = 0, dc_hold = 0, opt_rem = 0, opt_hold = 0, g = 0;

    reset_led_ctrl #(
        .PULSE_CYCLES  (P),
        .HOLDOFF_CYCLES(H),
        .CNT_W         (32),
        .SLOW_BIT      (SB),
        .FAST_BIT      (FB)
    ) dut (
        .clock        (clock),
        .nreset       (nreset),
        .reset_dc_req (reset_dc_req),
        .reset_opt_req(reset_opt_req),
        .reset_conf   (reset_conf),
        .pll_ready    (pll_ready),
        .resync_active(resync_active),
        .adv_ready    (adv_ready),
        .dc_nreset_oe (dc_nreset_oe),
        .opt_nreset_oe(opt_nreset_oe),
        .led_oe       (led_oe),
        .led_out      (led_out),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic glow_exp(input int gv, input int b);
        int t, lvl;
        t   = (gv >> (b - 8)) % 512;
        lvl = (t < 256) ? t : 511 - t;
        return (gv % 256) < lvl;
    endfunction

    task automatic chan_step(inout int rem, inout int hold, input logic req);
        if (req && (rem > 0 || hold == 0)) begin
            rem = P;
        end else if (rem > 0) begin
            rem--;
            if (rem == 0) hold = H;
        end else if (hold > 0) begin
            hold--;
        end
    endtask

    // Reference model, evaluated on each rising edge from the stable inputs.
    initial forever begin
        exp_t e;
        @(posedge clock);
        if (!nreset) begin
            dc_rem = 0; dc_hold = 0; opt_rem = 0; opt_hold = 0; g = 0;
            e = '{dc: 1'b0, opt: 1'b0, busy: 1'b0, led_oe: 1'b1, led_out: 1'b1};
        end else begin
            chan_step(dc_rem, dc_hold, reset_dc_req);
            chan_step(opt_rem, opt_hold, reset_opt_req);
            e.dc   = (dc_rem > 0);
            e.opt  = (opt_rem > 0);
            e.busy = (dc_rem > 0) || (dc_hold > 0) || (opt_rem > 0) || (opt_hold > 0);
            if (reset_conf == 8'd2) begin
                e.led_oe = e.dc; e.led_out = 1'b0;
            end else if (reset_conf != 8'd0) begin
                e.led_oe = e.opt; e.led_out = 1'b0;
            end else begin
                e.led_oe = 1'b1;
                if (!pll_ready)         e.led_out = 1'b1;
                else if (resync_active) e.led_out = ~glow_exp(g, FB);
                else if (adv_ready)     e.led_out = 1'b0;
                else                    e.led_out = ~glow_exp(g, SB);
            end
            g = (g + 1) % GMOD;
        end
        sb_q.push_back(e);
    end

    // Scoreboard checker on the falling edge.
    initial forever begin
        exp_t e;
        @(negedge clock);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("dc_oe",   dc_nreset_oe,  e.dc);
            check("opt_oe",  opt_nreset_oe, e.opt);
            check("busy",    busy,          e.busy);
            check("led_oe",  led_oe,        e.led_oe);
            check("led_out", led_out,       e.led_out);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int  n, m;
        bit  saw0, saw1;
        nreset = 1'b0; reset_dc_req = 1'b0; reset_opt_req = 1'b0;
        reset_conf = 8'd0; pll_ready = 1'b0; resync_active = 1'b0; adv_ready = 1'b0;
        tick(3);
        nreset = 1'b1;
        tick(10);
        check("idle_dc_oe",  dc_nreset_oe,  0);
        check("idle_opt_oe", opt_nreset_oe, 0);
        check("idle_busy",   busy,          0);
        check("idle_led_oe", led_oe,        1);
        check("idle_led_off", led_out,      1);

        // Single pulse, requests during holdoff, re-fire on first idle cycle.
        reset_dc_req = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (i == 0)  reset_dc_req = 1'b0;
            if (i == 10) reset_dc_req = 1'b1;
            if (i == 14) check("busy_end_holdoff", busy, 1);
            if (i == 15) check("idle_after_holdoff", busy, 0);
            if (i == 16) reset_dc_req = 1'b0;
            if (dc_nreset_oe) n++;
        end
        check("pulse_plus_refire_len", n, 2 * P);
        tick(20);

        // Retrigger 5 cycles into the pulse.
        reset_dc_req = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (i == 0) reset_dc_req = 1'b0;
            if (i == 4) reset_dc_req = 1'b1;
            if (i == 5) reset_dc_req = 1'b0;
            if (dc_nreset_oe) n++;
        end
        check("retrigger_len", n, P + 5);
        tick(10);

        // DC mirror mode: an opt-only request must not light the pin.
        reset_conf = 8'd2;
        @(negedge clock);
        reset_opt_req = 1'b1;
        n = 0; m = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (i == 0) reset_opt_req = 1'b0;
            if (led_oe) n++;
            if (opt_nreset_oe) m++;
        end
        check("conf2_led_oe_cycles", n, 0);
        check("conf2_opt_len", m, P);

        // Opt mirror mode with an arbitrary code.
        reset_conf = 8'd5;
        @(negedge clock);
        reset_opt_req = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (i == 0) reset_opt_req = 1'b0;
            if (led_oe && !led_out) n++;
        end
        check("conf5_led_on_cycles", n, P);

        // Status mode glows.
        reset_conf = 8'd0; pll_ready = 1'b1;
        saw0 = 1'b0; saw1 = 1'b0;
        for (int i = 0; i < 8300; i++) begin
            @(negedge clock);
            if (led_out) saw1 = 1'b1; else saw0 = 1'b1;
        end
        check("slow_glow_toggles", int'(saw0 && saw1), 1);
        adv_ready = 1'b1;
        @(negedge clock);
        check("adv_ready_led_on", led_out, 0);
        resync_active = 1'b1;
        saw0 = 1'b0; saw1 = 1'b0;
        for (int i = 0; i < 2200; i++) begin
            @(negedge clock);
            if (led_out) saw1 = 1'b1; else saw0 = 1'b1;
        end
        check("fast_glow_toggles", int'(saw0 && saw1), 1);
        resync_active = 1'b0; adv_ready = 1'b0;

        // Reset in the middle of a pulse, then a clean full pulse.
        reset_dc_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (i == 0) reset_dc_req = 1'b0;
        end
        nreset = 1'b0;
        @(negedge clock);
        check("mid_reset_oe", dc_nreset_oe, 0);
        check("mid_reset_busy", busy, 0);
        nreset = 1'b1;
        tick(2);
        reset_dc_req = 1'b1;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (i == 0) reset_dc_req = 1'b0;
            if (dc_nreset_oe) n++;
        end
        check("post_reset_pulse_len", n, P);

        // Random mix of requests, modes and status inputs.
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            reset_dc_req  = ($urandom_range(0, 7) == 0);
            reset_opt_req = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 4))
                    0: reset_conf = 8'd0;
                    1: reset_conf = 8'd1;
                    2: reset_conf = 8'd2;
                    3: reset_conf = 8'd3;
                    default: reset_conf = 8'd255;
                endcase
            end
            pll_ready     = ($urandom_range(0, 3) != 0);
            resync_active = ($urandom_range(0, 3) == 0);
            adv_ready     = $urandom_range(0, 1) == 1;
        end
        reset_dc_req = 1'b0; reset_opt_req = 1'b0;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
